// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the hazard controller:
//   hazard_type_e  - pool kind (LAVA / WATER / GOO / NONE)
//   player_state_e - per-player life-cycle state
//   pool_t         - one entry of the pool table {x, y, ptype}
//   is_lethal()    - whether a pool kind kills a given player
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_LAVA  = 2'd0,    // kills player 2 only
        HZ_WATER = 2'd1,    // kills player 1 only
        HZ_GOO   = 2'd2,    // kills both players
        HZ_NONE  = 2'd3     // inert slot
    } hazard_type_e;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_DYING = 2'd1,
        ST_DEAD  = 2'd2,
        ST_GRACE = 2'd3
    } player_state_e;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        hazard_type_e       ptype;
    } pool_t;

    localparam pool_t POOL_RESET = '{x: 16'sd0, y: 16'sd0, ptype: HZ_NONE};

    // for_p2 = 0 asks about player 1, 1 asks about player 2.
    function automatic logic is_lethal(input hazard_type_e t, input logic for_p2);
        case (t)
            HZ_LAVA:  is_lethal = for_p2;
            HZ_WATER: is_lethal = !for_p2;
            HZ_GOO:   is_lethal = 1'b1;
            default:  is_lethal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_controller_player_fsm.sv
// -----------------------------------------------------------------------------
// hazard_player_fsm
// Life-cycle of one player: ALIVE -> DYING -> DEAD, restarted through GRACE
// by level_clear. Counts frame ticks while dying and while in grace, and
// latches the index of the pool that caused the death.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   frame_tick          - one-cycle pulse per video frame
//   level_clear         - synchronous restart, wins over hit
//   hit, hit_idx        - registered lethal overlap and the pool it came from
//   dying, dead         - registered state decodes
//   death_pulse         - one-cycle pulse on the ALIVE -> DYING transition
//   cause               - pool index that killed the player (0 after clear)
// -----------------------------------------------------------------------------
module hazard_player_fsm
    import hazard_pkg::*;
#(
    parameter int DEATH_FRAMES = 30,
    parameter int GRACE_FRAMES = 60,
    parameter int IDX_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             level_clear,
    input  logic             hit,
    input  logic [IDX_W-1:0] hit_idx,
    output logic             dying,
    output logic             dead,
    output logic             death_pulse,
    output logic [IDX_W-1:0] cause
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    // Count value seen on the tick that completes the interval.
    localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_FRAMES - 1);

    player_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] cause_q, cause_d;
    logic             pulse_q, pulse_d;
    logic             dying_q, dying_d;
    logic             dead_q, dead_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        pulse_d = 1'b0;

        if (level_clear) begin
            state_d = ST_GRACE;
            cnt_d   = '0;
            cause_d = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit) begin
                        state_d = ST_DYING;
                        cnt_d   = '0;
                        cause_d = hit_idx;
                        pulse_d = 1'b1;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (cnt_q == DEATH_LAST) begin
                            state_d = ST_DEAD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
                ST_GRACE: begin
                    if (GRACE_FRAMES == 0) begin
                        state_d = ST_ALIVE;
                    end else if (frame_tick) begin
                        if (cnt_q == GRACE_LAST) begin
                            state_d = ST_ALIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_ALIVE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Decode from the next state so the flags line up with state_q.
        dying_d = (state_d == ST_DYING);
        dead_d  = (state_d == ST_DEAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ALIVE;
            cnt_q   <= '0;
            cause_q <= '0;
            pulse_q <= 1'b0;
            dying_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pulse_q <= pulse_d;
            dying_q <= dying_d;
            dead_q  <= dead_d;
        end
    end

    assign dying       = dying_q;
    assign dead        = dead_q;
    assign death_pulse = pulse_q;
    assign cause       = cause_q;

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Holds a small table of hazard pools, scans one pool per cycle against both
// player bounding boxes, registers the lethal overlap and feeds it to one
// life-cycle FSM per player.
// Ports:
//   Clk, Reset_n                  - clock, asynchronous active-low reset
//   frame_tick                    - one-cycle pulse per video frame
//   level_clear                   - synchronous level restart
//   cfg_we/idx/x/y/type           - pool table write port
//   p{1,2}_{top,bottom,left,right}- signed player bounding boxes
//   p{1,2}_dead, p{1,2}_dying     - registered player state flags
//   p{1,2}_death_pulse            - one-cycle death event
//   p{1,2}_cause                  - index of the pool that killed the player
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int NUM_POOLS    = 4,
    parameter int POOL_W       = 76,
    parameter int POOL_H       = 5,
    parameter int DEATH_FRAMES = 30,
    parameter int GRACE_FRAMES = 60,
    localparam int IDX_W       = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               level_clear,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic signed [15:0] cfg_x,
    input  logic signed [15:0] cfg_y,
    input  logic [1:0]         cfg_type,
    input  logic signed [15:0] p1_top,
    input  logic signed [15:0] p1_bottom,
    input  logic signed [15:0] p1_left,
    input  logic signed [15:0] p1_right,
    input  logic signed [15:0] p2_top,
    input  logic signed [15:0] p2_bottom,
    input  logic signed [15:0] p2_left,
    input  logic signed [15:0] p2_right,
    output logic               p1_dead,
    output logic               p2_dead,
    output logic               p1_dying,
    output logic               p2_dying,
    output logic               p1_death_pulse,
    output logic               p2_death_pulse,
    output logic [IDX_W-1:0]   p1_cause,
    output logic [IDX_W-1:0]   p2_cause
);

    localparam logic signed [16:0] POOL_W_S = 17'(POOL_W);
    localparam logic signed [16:0] POOL_H_S = 17'(POOL_H);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_POOLS - 1);

    // Strict overlap, widened to 17 signed bits so x+POOL_W cannot wrap.
    function automatic logic box_overlap(
        input pool_t              p,
        input logic signed [15:0] top,
        input logic signed [15:0] bottom,
        input logic signed [15:0] left,
        input logic signed [15:0] right
    );
        logic signed [16:0] px, py, bt, bb, bl, br;
        px = {p.x[15], p.x};
        py = {p.y[15], p.y};
        bt = {top[15], top};
        bb = {bottom[15], bottom};
        bl = {left[15], left};
        br = {right[15], right};
        box_overlap = (br > px) && (bl < px + POOL_W_S) &&
                      (bb > py) && (bt < py + POOL_H_S);
    endfunction

    // Reset release is brought into the clock domain before scanning starts,
    // so a release near an edge cannot produce a partial first compare.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       scan_run;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign scan_run   = rst_sync_q[1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Pool table.
    pool_t pool_q [NUM_POOLS];
    pool_t pool_d [NUM_POOLS];

    always_comb begin
        for (int i = 0; i < NUM_POOLS; i++) begin
            pool_d[i] = pool_q[i];
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                pool_d[i] = '{x: cfg_x, y: cfg_y, ptype: hazard_type_e'(cfg_type)};
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_POOLS; i++) begin
                pool_q[i] <= POOL_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_POOLS; i++) begin
                pool_q[i] <= pool_d[i];
            end
        end
    end

    // Scanner: one pool per cycle, compare result registered for the FSMs.
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic             hit_p1_q, hit_p1_d;
    logic             hit_p2_q, hit_p2_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    pool_t            cur_pool;

    always_comb begin
        cur_pool   = pool_q[scan_idx_q];
        scan_idx_d = scan_idx_q;
        hit_p1_d   = 1'b0;
        hit_p2_d   = 1'b0;
        hit_idx_d  = scan_idx_q;

        if (!scan_run || level_clear) begin
            scan_idx_d = '0;
        end else begin
            hit_p1_d = is_lethal(cur_pool.ptype, 1'b0) &&
                       box_overlap(cur_pool, p1_top, p1_bottom, p1_left, p1_right);
            hit_p2_d = is_lethal(cur_pool.ptype, 1'b1) &&
                       box_overlap(cur_pool, p2_top, p2_bottom, p2_left, p2_right);
            scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_idx_q <= '0;
            hit_p1_q   <= 1'b0;
            hit_p2_q   <= 1'b0;
            hit_idx_q  <= '0;
        end else begin
            scan_idx_q <= scan_idx_d;
            hit_p1_q   <= hit_p1_d;
            hit_p2_q   <= hit_p2_d;
            hit_idx_q  <= hit_idx_d;
        end
    end

    hazard_player_fsm #(
        .DEATH_FRAMES (DEATH_FRAMES),
        .GRACE_FRAMES (GRACE_FRAMES),
        .IDX_W        (IDX_W)
    ) u_p1_fsm (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_tick  (frame_tick),
        .level_clear (level_clear),
        .hit         (hit_p1_q),
        .hit_idx     (hit_idx_q),
        .dying       (p1_dying),
        .dead        (p1_dead),
        .death_pulse (p1_death_pulse),
        .cause       (p1_cause)
    );

    hazard_player_fsm #(
        .DEATH_FRAMES (DEATH_FRAMES),
        .GRACE_FRAMES (GRACE_FRAMES),
        .IDX_W        (IDX_W)
    ) u_p2_fsm (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_tick  (frame_tick),
        .level_clear (level_clear),
        .hit         (hit_p2_q),
        .hit_idx     (hit_idx_q),
        .dying       (p2_dying),
        .dead        (p2_dead),
        .death_pulse (p2_death_pulse),
        .cause       (p2_cause)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed scenarios for the hazard controller followed by randomized pool
// tables checked against a reference model of the overlap/lethality rules.
// -----------------------------------------------------------------------------
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int NP = 4;
    localparam int PW = 76;
    localparam int PH = 5;
    localparam int DF = 30;
    localparam int GF = 60;
    localparam int IW = 2;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               level_clear = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IW-1:0]      cfg_idx = '0;
    logic signed [15:0] cfg_x = '0;
    logic signed [15:0] cfg_y = '0;
    logic [1:0]         cfg_type = '0;
    logic signed [15:0] p1_top = -16'sd2000, p1_bottom = -16'sd1990;
    logic signed [15:0] p1_left = -16'sd2000, p1_right = -16'sd1990;
    logic signed [15:0] p2_top = -16'sd2000, p2_bottom = -16'sd1990;
    logic signed [15:0] p2_left = -16'sd2000, p2_right = -16'sd1990;
    logic               p1_dead, p2_dead, p1_dying, p2_dying;
    logic               p1_death_pulse, p2_death_pulse;
    logic [IW-1:0]      p1_cause, p2_cause;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_controller #(
        .NUM_POOLS    (NP),
        .POOL_W       (PW),
        .POOL_H       (PH),
        .DEATH_FRAMES (DF),
        .GRACE_FRAMES (GF)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_tick     (frame_tick),
        .level_clear    (level_clear),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_x          (cfg_x),
        .cfg_y          (cfg_y),
        .cfg_type       (cfg_type),
        .p1_top         (p1_top),
        .p1_bottom      (p1_bottom),
        .p1_left        (p1_left),
        .p1_right       (p1_right),
        .p2_top         (p2_top),
        .p2_bottom      (p2_bottom),
        .p2_left        (p2_left),
        .p2_right       (p2_right),
        .p1_dead        (p1_dead),
        .p2_dead        (p2_dead),
        .p1_dying       (p1_dying),
        .p2_dying       (p2_dying),
        .p1_death_pulse (p1_death_pulse),
        .p2_death_pulse (p2_death_pulse),
        .p1_cause       (p1_cause),
        .p2_cause       (p2_cause)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_pool(input int idx, input int x, input int y, input int t);
        cfg_idx  = IW'(idx);
        cfg_x    = 16'(x);
        cfg_y    = 16'(y);
        cfg_type = 2'(t);
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic box1(input int l, input int r, input int t, input int b);
        p1_left = 16'(l); p1_right = 16'(r); p1_top = 16'(t); p1_bottom = 16'(b);
    endtask

    task automatic box2(input int l, input int r, input int t, input int b);
        p2_left = 16'(l); p2_right = 16'(r); p2_top = 16'(t); p2_bottom = 16'(b);
    endtask

    task automatic boxes_far();
        box1(-2000, -1990, -2000, -1990);
        box2(-2000, -1990, -2000, -1990);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        step();
    endtask

    // Bring both players back to ALIVE: clear, then the full grace period.
    task automatic revive();
        boxes_far();
        level_clear = 1'b1;
        step();
        level_clear = 1'b0;
        for (int k = 0; k < GF; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        step();
    endtask

    // Reference model: spec overlap rule in plain integers.
    function automatic bit model_overlap(input int px, input int py,
                                         input int l, input int r, input int t, input int b);
        return (r > px) && (l < px + PW) && (b > py) && (t < py + PH);
    endfunction

    function automatic bit model_kills(input int ptype, input bit for_p2);
        if (ptype == 2) return 1'b1;
        if (ptype == 0) return for_p2;
        if (ptype == 1) return !for_p2;
        return 1'b0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({p1_dead, p2_dead, p1_dying, p2_dying, p1_death_pulse, p2_death_pulse} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {p1_dead, p2_dead, p1_dying, p2_dying, p1_death_pulse, p2_death_pulse});
        end
        n_checks++;
        if ({p1_cause, p2_cause} !== '0) begin
            n_fail++;
            $display("FAIL reset_cause: got %0d/%0d expected 0/0", p1_cause, p2_cause);
        end
        Reset_n = 1'b1;
        step();
        step();
        $display("test_reset done");
    endtask

    task automatic test_water_hit();
        int p1_pulses = 0, p2_pulses = 0;
        logic [IW-1:0] cause_seen = '1;
        write_pool(0, 300, 463, 1);
        box1(310, 330, 450, 470);
        box2(310, 330, 450, 470);
        for (int s = 0; s < 6; s++) begin
            step();
            if (p1_death_pulse) begin p1_pulses++; cause_seen = p1_cause; end
            if (p2_death_pulse) p2_pulses++;
        end
        n_checks++;
        if (p1_pulses !== 1) begin n_fail++; $display("FAIL water_p1_pulses: got %0d expected 1", p1_pulses); end
        n_checks++;
        if (cause_seen !== 2'd0) begin n_fail++; $display("FAIL water_p1_cause: got %0d expected 0", cause_seen); end
        n_checks++;
        if (p1_dying !== 1'b1) begin n_fail++; $display("FAIL water_p1_dying: got %0b expected 1", p1_dying); end
        n_checks++;
        if (p2_pulses !== 0 || p2_dying !== 1'b0) begin
            n_fail++;
            $display("FAIL water_p2_unaffected: got pulses=%0d dying=%0b expected 0/0", p2_pulses, p2_dying);
        end
        $display("test_water_hit p1_pulses=%0d cause=%0d", p1_pulses, cause_seen);
    endtask

    task automatic test_death_count();
        int extra = 0;
        for (int k = 1; k <= DF; k++) begin
            logic exp_dead;
            exp_dead = (k == DF);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            n_checks++;
            if (p1_dead !== exp_dead || p1_dying !== !exp_dead) begin
                n_fail++;
                $display("FAIL death_tick%0d: got dead=%0b dying=%0b expected dead=%0b", k, p1_dead, p1_dying, exp_dead);
            end
            step();
        end
        for (int s = 0; s < 12; s++) begin
            step();
            if (p1_death_pulse) extra++;
        end
        n_checks++;
        if (extra !== 0 || p1_dead !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_holds: got pulses=%0d dead=%0b expected 0/1", extra, p1_dead);
        end
        $display("test_death_count dead=%0b", p1_dead);
    endtask

    task automatic test_goo_both();
        int c1 = -1, c2 = -1;
        logic [IW-1:0] k1 = '0, k2 = '0;
        revive();
        n_checks++;
        if ({p1_dead, p1_dying, p2_dead, p2_dying} !== 4'b0) begin
            n_fail++;
            $display("FAIL revive_state: got %b expected 0000", {p1_dead, p1_dying, p2_dead, p2_dying});
        end
        write_pool(3, 396, 363, 2);
        box1(400, 420, 360, 365);
        box2(400, 420, 360, 365);
        for (int s = 1; s <= NP + 2; s++) begin
            step();
            if (p1_death_pulse && c1 < 0) begin c1 = s; k1 = p1_cause; end
            if (p2_death_pulse && c2 < 0) begin c2 = s; k2 = p2_cause; end
        end
        n_checks++;
        if (c1 < 0 || c1 !== c2) begin
            n_fail++;
            $display("FAIL goo_same_cycle: got p1@%0d p2@%0d expected equal and present", c1, c2);
        end
        n_checks++;
        if (k1 !== 2'd3 || k2 !== 2'd3) begin
            n_fail++;
            $display("FAIL goo_cause: got %0d/%0d expected 3/3", k1, k2);
        end
        $display("test_goo_both p1@%0d p2@%0d", c1, c2);
    endtask

    task automatic test_edge();
        int pulses = 0;
        logic [IW-1:0] k = '0;
        revive();
        write_pool(1, 100, 100, 0);
        box2(80, 100, 100, 104);        // right == x: touching only
        for (int s = 0; s < 3 * NP; s++) begin
            step();
            if (p2_death_pulse) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL edge_touch: got %0d pulses expected 0", pulses); end
        box2(80, 101, 100, 104);        // one pixel of overlap
        pulses = 0;
        for (int s = 0; s < NP + 1; s++) begin
            step();
            if (p2_death_pulse) begin pulses++; k = p2_cause; end
        end
        n_checks++;
        if (pulses !== 1 || k !== 2'd1) begin
            n_fail++;
            $display("FAIL edge_overlap: got pulses=%0d cause=%0d expected 1/1", pulses, k);
        end
        $display("test_edge overlap pulses=%0d", pulses);
    endtask

    task automatic test_lc_override();
        int found = -1;
        revive();
        for (int i = 0; i < NP; i++) write_pool(i, 300, 463, 1);
        box1(310, 330, 450, 470);
        step();                         // compare now registered as a hit
        level_clear = 1'b1;
        step();                         // FSM sees hit and clear together
        level_clear = 1'b0;
        n_checks++;
        if (p1_death_pulse !== 1'b0 || p1_dying !== 1'b0 || p1_dead !== 1'b0) begin
            n_fail++;
            $display("FAIL lc_override: got pulse=%0b dying=%0b dead=%0b expected 0/0/0",
                     p1_death_pulse, p1_dying, p1_dead);
        end
        for (int k = 1; k <= GF; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            n_checks++;
            if (p1_death_pulse !== 1'b0 || p1_dying !== 1'b0) begin
                n_fail++;
                $display("FAIL grace_tick%0d: got pulse=%0b dying=%0b expected 0/0", k, p1_death_pulse, p1_dying);
            end
            if (k < GF) step();
        end
        for (int s = 1; s <= NP + 1; s++) begin
            step();
            if (p1_death_pulse && found < 0) found = s;
        end
        n_checks++;
        if (found < 0) begin n_fail++; $display("FAIL grace_end_death: got no pulse expected pulse"); end
        $display("test_lc_override death after grace at step %0d", found);
    endtask

    task automatic test_async_reset();
        int bad = 0;
        for (int k = 0; k < 5; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        n_checks++;
        if (p1_dying !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dying: got %0b expected 1", p1_dying); end
        Reset_n = 1'b0;
        #2;
        n_checks++;
        if ({p1_dead, p1_dying, p1_death_pulse, p2_dead, p2_dying, p2_death_pulse} !== 6'b0 ||
            {p1_cause, p2_cause} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b causes %0d/%0d expected zero",
                     {p1_dead, p1_dying, p1_death_pulse, p2_dead, p2_dying, p2_death_pulse}, p1_cause, p2_cause);
        end
        step();
        Reset_n = 1'b1;
        for (int s = 0; s < 3 * NP + 4; s++) begin
            step();
            if (p1_death_pulse || p1_dying || p2_death_pulse) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL table_cleared: got %0d hit cycles expected 0", bad); end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int px[NP], py[NP], pt[NP];
            int l1, r1, t1, b1, l2, r2, t2, b2;
            bit kill1[NP], kill2[NP];
            bit any1, any2;
            int n1, n2, s1, s2;
            logic [IW-1:0] k1, k2;
            do_reset();
            boxes_far();
            for (int i = 0; i < NP; i++) begin
                px[i] = int'($urandom_range(150));
                py[i] = int'($urandom_range(40));
                pt[i] = int'($urandom_range(3));
                write_pool(i, px[i], py[i], pt[i]);
            end
            l1 = int'($urandom_range(250)) - 50; r1 = l1 + int'($urandom_range(40));
            t1 = int'($urandom_range(60)) - 10;  b1 = t1 + int'($urandom_range(12));
            l2 = int'($urandom_range(250)) - 50; r2 = l2 + int'($urandom_range(40));
            t2 = int'($urandom_range(60)) - 10;  b2 = t2 + int'($urandom_range(12));
            any1 = 0; any2 = 0;
            for (int i = 0; i < NP; i++) begin
                kill1[i] = model_kills(pt[i], 1'b0) && model_overlap(px[i], py[i], l1, r1, t1, b1);
                kill2[i] = model_kills(pt[i], 1'b1) && model_overlap(px[i], py[i], l2, r2, t2, b2);
                any1 |= kill1[i];
                any2 |= kill2[i];
            end
            box1(l1, r1, t1, b1);
            box2(l2, r2, t2, b2);
            n1 = 0; n2 = 0; s1 = -1; s2 = -1; k1 = '0; k2 = '0;
            for (int s = 1; s <= 2 * NP + 4; s++) begin
                step();
                if (p1_death_pulse) begin n1++; if (s1 < 0) begin s1 = s; k1 = p1_cause; end end
                if (p2_death_pulse) begin n2++; if (s2 < 0) begin s2 = s; k2 = p2_cause; end end
            end
            n_checks++;
            if (n1 !== int'(any1) || (any1 && (s1 > NP + 1 || !kill1[k1]))) begin
                n_fail++;
                $display("FAIL rand%0d_p1: got pulses=%0d step=%0d cause=%0d expected pulses=%0d lethal-cause within %0d",
                         it, n1, s1, k1, any1, NP + 1);
            end
            n_checks++;
            if (n2 !== int'(any2) || (any2 && (s2 > NP + 1 || !kill2[k2]))) begin
                n_fail++;
                $display("FAIL rand%0d_p2: got pulses=%0d step=%0d cause=%0d expected pulses=%0d lethal-cause within %0d",
                         it, n2, s2, k2, any2, NP + 1);
            end
            $display("rand%0d p1 exp=%0b got=%0d p2 exp=%0b got=%0d", it, any1, n1, any2, n2);
        end
    endtask

    initial begin
        test_reset();
        test_water_hit();
        test_death_count();
        test_goo_both();
        test_edge();
        test_lc_override();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
